phy_nibble_rx: RTL

//  Receive-side counterpart of the xmit PHY path. Samples the 4-bit PHY receive bus,

---
 rtl/rx_pkg.sv | 36 +++
 rtl/nibble_packer.sv | 61 ++++++
 rtl/phy_nibble_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pkg
//  Description : Shared definitions for the PHY nibble receive path: field
//                widths, preamble/SFD nibble codes, FSM state encoding and
//                the end-of-frame control word packer. The xmit control block
//                decoder uses the same packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 12;
    localparam int CTRL_W = 24;

    localparam logic [NIB_W-1:0] PREAMBLE_NIB = 4'h5;
    localparam logic [NIB_W-1:0] SFD_NIB      = 4'hD;

    // Receive FSM state encoding
    localparam int              ST_W        = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_PREAMBLE = 2'd1;
    localparam logic [ST_W-1:0] ST_DATA     = 2'd2;
    localparam logic [ST_W-1:0] ST_DROP     = 2'd3;

    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Control word carries the byte count twice: {len, len}
    function automatic ctrl_t pack_ctrl(input len_t len);
        return {len, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_packer
//  Description : Packs successive 4-bit nibbles into bytes, low nibble first.
//                A one-cycle byte strobe follows the edge that captures the
//                high nibble.
//  Ports       : clk        - clock
//                rst_n      - asynchronous active-low reset
//                clear      - force phase back to low nibble (start of data)
//                nib_en     - nib is a valid data nibble this cycle
//                nib        - data nibble
//                phase_hi   - 1 when the next accepted nibble is the high one
//                byte_out   - assembled byte
//                byte_valid - one-cycle strobe, byte_out complete
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_packer
    import rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              nib_en,
    input  logic [NIB_W-1:0]  nib,
    output logic              phase_hi,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid
);

    logic              r_phase;
    logic [BYTE_W-1:0] r_byte;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clear) begin
                r_phase <= 1'b0;
            end else if (nib_en) begin
                if (!r_phase) begin
                    r_byte[3:0] <= nib;
                    r_phase     <= 1'b1;
                end else begin
                    r_byte[7:4] <= nib;
                    r_phase     <= 1'b0;
                    r_valid     <= 1'b1;
                end
            end
        end
    end

    assign phase_hi   = r_phase;
    assign byte_out   = r_byte;
    assign byte_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/phy_nibble_rx.sv
`default_nettype none
// ============================================================================
//  Module      : phy_nibble_rx
//  Description : PHY nibble receive path. Samples the 4-bit PHY receive bus,
//                detects preamble/SFD, packs nibbles into bytes and reports
//                end of frame as either a good-frame strobe with a {len,len}
//                control word or an error strobe.
//  Ports       : clk_phy       - PHY clock (only clock)
//                reset         - asynchronous active-low reset
//                phy_rx_dv     - receive data valid
//                phy_data_in   - receive nibble
//                r_data_out    - assembled byte
//                r_data_valid  - one-cycle byte strobe
//                r_frame_valid - one-cycle good-frame strobe
//                r_ctrl_out    - {len,len}, held until next good frame
//                r_frame_err   - one-cycle bad/aborted frame strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_nibble_rx
    import rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,   // must be <= 4095
    parameter int PRE_MIN = 2
) (
    input  logic              clk_phy,
    input  logic              reset,
    input  logic              phy_rx_dv,
    input  logic [NIB_W-1:0]  phy_data_in,
    output logic [BYTE_W-1:0] r_data_out,
    output logic              r_data_valid,
    output logic              r_frame_valid,
    output logic [CTRL_W-1:0] r_ctrl_out,
    output logic              r_frame_err
);

    localparam len_t       c_min_len = LEN_W'(MIN_LEN);
    localparam len_t       c_max_len = LEN_W'(MAX_LEN);
    localparam logic [3:0] c_pre_min = 4'(PRE_MIN);

    logic [ST_W-1:0] r_state;
    logic [3:0]      r_pre_cnt;
    len_t            r_len;

    logic w_sfd_hit;
    logic w_nib_en;
    logic w_phase_hi;
    logic w_byte_done;
    logic w_len_ok;
    logic w_good;

    // SFD only counts once enough preamble nibbles have been seen
    assign w_sfd_hit   = (r_state == ST_PREAMBLE) && phy_rx_dv &&
                         (phy_data_in == SFD_NIB) && (r_pre_cnt >= c_pre_min);
    assign w_nib_en    = (r_state == ST_DATA) && phy_rx_dv;
    assign w_byte_done = w_nib_en && w_phase_hi;
    assign w_len_ok    = (r_len >= c_min_len) && (r_len <= c_max_len);
    // A dangling low nibble (phase still high) means an odd nibble count
    assign w_good      = !w_phase_hi && w_len_ok;

    nibble_packer u_packer (
        .clk        (clk_phy),
        .rst_n      (reset),
        .clear      (w_sfd_hit),
        .nib_en     (w_nib_en),
        .nib        (phy_data_in),
        .phase_hi   (w_phase_hi),
        .byte_out   (r_data_out),
        .byte_valid (r_data_valid)
    );

    // Byte counter; saturates so an oversize frame can never wrap back into
    // the legal window.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            r_len <= '0;
        end else if (w_sfd_hit) begin
            r_len <= '0;
        end else if (w_byte_done && (r_len != {LEN_W{1'b1}})) begin
            r_len <= r_len + 1'b1;
        end
    end

    // Receive FSM and end-of-frame strobes
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pre_cnt     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_ctrl_out    <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (phy_rx_dv) begin
                        if (phy_data_in == PREAMBLE_NIB) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= 4'd1;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!phy_rx_dv) begin
                        r_state <= ST_IDLE;
                    end else if (phy_data_in == PREAMBLE_NIB) begin
                        if (r_pre_cnt != 4'hF) begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                        end
                    end else if (w_sfd_hit) begin
                        r_state <= ST_DATA;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    // r_len already includes the final byte here: its count
                    // was taken on the edge that captured its high nibble.
                    if (!phy_rx_dv) begin
                        r_state <= ST_IDLE;
                        if (w_good) begin
                            r_frame_valid <= 1'b1;
                            r_ctrl_out    <= pack_ctrl(r_len);
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!phy_rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
